// File: rtl/sha256_mem_responder_if.sv
// Memory-port and host-load bundle between the SHA-256 engine/host and the
// memory responder. The master side is the engine plus host loader; the
// slave side is the responder.
interface sha256_mem_responder_if;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;

    modport master (
        output mem_addr, mem_we, mem_write_data, ld_valid, ld_addr, ld_data,
        input  mem_read_data, ld_ready
    );

    modport slave (
        input  mem_addr, mem_we, mem_write_data, ld_valid, ld_addr, ld_data,
        output mem_read_data, ld_ready
    );
endinterface

// File: rtl/sha256_mem_responder.sv
// Word-addressed memory responder behind the SHA-256 engine's memory port.
// Serves engine reads with a fixed pipelined latency, absorbs engine writes,
// captures the 8-word digest written into a fixed window, and accepts host
// preloads whenever the engine is not writing.
module sha256_mem_responder #(
    parameter int          DEPTH        = 256,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] DIGEST_BASE  = 16'h0020
) (
    input  logic                   clk,
    input  logic                   reset,
    sha256_mem_responder_if.slave  bus,
    input  logic                   digest_clr,
    input  logic [2:0]             digest_sel,
    output logic [31:0]            digest_word,
    output logic                   digest_valid,
    output logic                   oor_err,
    output logic [15:0]            rd_count
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    localparam logic [16:0] WIN_LO  = {1'b0, DIGEST_BASE};
    localparam logic [16:0] WIN_HI  = {1'b0, DIGEST_BASE} + 17'd8;

    logic [31:0] mem [DEPTH];

    logic        eng_in_range;
    logic        ld_in_range;
    logic        ld_fire;
    logic        win_hit;
    logic [2:0]  win_off;

    logic [31:0] rd_data_p0;
    logic        rd_vld_p0;
    logic [31:0] out_data;
    logic        out_vld;

    logic [31:0] rdata_q,  rdata_d;
    logic [15:0] rdcnt_q,  rdcnt_d;
    logic        oor_q,    oor_d;
    logic [7:0]  mask_q,   mask_d;
    logic        dvalid_q, dvalid_d;
    logic [31:0] digest_q [8];

    assign eng_in_range = ({1'b0, bus.mem_addr} < DEPTH_W);
    assign ld_in_range  = ({1'b0, bus.ld_addr} < DEPTH_W);

    // The engine owns the array whenever it writes; the host fills otherwise.
    assign bus.ld_ready = ~bus.mem_we & ~reset;
    assign ld_fire      = bus.ld_valid & ~bus.mem_we;

    assign win_hit = bus.mem_we &&
                     ({1'b0, bus.mem_addr} >= WIN_LO) &&
                     ({1'b0, bus.mem_addr} <  WIN_HI);
    // Low three bits of (addr - base) are exact inside the 8-word window.
    assign win_off = bus.mem_addr[2:0] - DIGEST_BASE[2:0];

    // Stage 0: array read at the sampling edge (old contents, read-first)
    assign rd_vld_p0  = ~bus.mem_we;
    assign rd_data_p0 = eng_in_range ? mem[bus.mem_addr[AW-1:0]] : 32'h0;

    // Array writes; nothing commits at an edge where reset is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset) begin
            if (bus.mem_we) begin
                if (eng_in_range) begin
                    mem[bus.mem_addr[AW-1:0]] <= bus.mem_write_data;
                end
            end else if (ld_fire && ld_in_range) begin
                mem[bus.ld_addr[AW-1:0]] <= bus.ld_data;
            end
        end
    end

    // Stages 1..READ_LATENCY-1: delay line between the array read and the output register
    generate
        if (READ_LATENCY <= 1) begin : g_lat1
            assign out_data = rd_data_p0;
            assign out_vld  = rd_vld_p0;
        end else begin : g_latn
            logic [31:0] rd_data_pn [READ_LATENCY-1];
            logic        rd_vld_pn  [READ_LATENCY-1];

            // Valid bits are flushed by reset so in-flight reads are discarded.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < READ_LATENCY - 1; k++) begin
                        rd_vld_pn[k] <= 1'b0;
                    end
                end else begin
                    rd_vld_pn[0] <= rd_vld_p0;
                    for (int k = 1; k < READ_LATENCY - 1; k++) begin
                        rd_vld_pn[k] <= rd_vld_pn[k-1];
                    end
                end
            end

            // Data shifts freely; only the valid bits qualify it.
            always_ff @(posedge clk) begin
                rd_data_pn[0] <= rd_data_p0;
                for (int k = 1; k < READ_LATENCY - 1; k++) begin
                    rd_data_pn[k] <= rd_data_pn[k-1];
                end
            end

            assign out_data = rd_data_pn[READ_LATENCY-2];
            assign out_vld  = rd_vld_pn[READ_LATENCY-2];
        end
    endgenerate

    // Next-state for read data, counters, error flag and digest mask.
    always_comb begin
        rdata_d  = rdata_q;
        rdcnt_d  = rdcnt_q;
        oor_d    = oor_q;
        mask_d   = mask_q;
        if (out_vld) begin
            rdata_d = out_data;
        end
        if (rd_vld_p0 && (rdcnt_q != 16'hFFFF)) begin
            rdcnt_d = rdcnt_q + 16'd1;
        end
        if (!eng_in_range) begin
            oor_d = 1'b1;
        end
        // Clear first, then the word written this cycle re-marks its bit.
        if (digest_clr) begin
            mask_d = 8'h00;
        end
        if (win_hit) begin
            mask_d[win_off] = 1'b1;
        end
        dvalid_d = &mask_d;
    end

    // Control and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q  <= 32'h0;
            rdcnt_q  <= 16'h0;
            oor_q    <= 1'b0;
            mask_q   <= 8'h00;
            dvalid_q <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                digest_q[k] <= 32'h0;
            end
        end else begin
            rdata_q  <= rdata_d;
            rdcnt_q  <= rdcnt_d;
            oor_q    <= oor_d;
            mask_q   <= mask_d;
            dvalid_q <= dvalid_d;
            if (win_hit) begin
                digest_q[win_off] <= bus.mem_write_data;
            end
        end
    end

    assign bus.mem_read_data = rdata_q;
    assign rd_count          = rdcnt_q;
    assign oor_err           = oor_q;
    assign digest_valid      = dvalid_q;
    assign digest_word       = digest_q[digest_sel];

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Directed bench for sha256_mem_responder: one DUT at read latency 1 and one
// at read latency 3, sharing clock and reset.
module tb_sha256_mem_responder;

    logic clk;
    logic reset;

    int errors;
    int checks;

    sha256_mem_responder_if if1 ();
    sha256_mem_responder_if if3 ();

    logic        clr1, clr3;
    logic [2:0]  sel1, sel3;
    logic [31:0] word1, word3;
    logic        valid1, valid3;
    logic        oor1, oor3;
    logic [15:0] cnt1, cnt3;

    sha256_mem_responder #(.DEPTH(256), .READ_LATENCY(1), .DIGEST_BASE(16'h0020)) u1 (
        .clk(clk), .reset(reset), .bus(if1.slave),
        .digest_clr(clr1), .digest_sel(sel1), .digest_word(word1),
        .digest_valid(valid1), .oor_err(oor1), .rd_count(cnt1)
    );

    sha256_mem_responder #(.DEPTH(256), .READ_LATENCY(3), .DIGEST_BASE(16'h0020)) u3 (
        .clk(clk), .reset(reset), .bus(if3.slave),
        .digest_clr(clr3), .digest_sel(sel3), .digest_word(word3),
        .digest_valid(valid3), .oor_err(oor3), .rd_count(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (if1.mem_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", if1.mem_read_data); end
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_dvalid got=%b exp=0", valid1); end
        checks++; if (oor1 !== 1'b0) begin errors++; $display("FAIL reset_oor got=%b exp=0", oor1); end
        checks++; if (cnt1 !== 16'h0) begin errors++; $display("FAIL reset_rdcount got=%0d exp=0", cnt1); end
        checks++; if (word1 !== 32'h0) begin errors++; $display("FAIL reset_dword got=%h exp=0", word1); end
        checks++; if (if1.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ldready got=%b exp=0", if1.ld_ready); end
        checks++; if (if3.mem_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata3 got=%h exp=0", if3.mem_read_data); end
        reset = 1'b0;
    endtask

    task automatic test_load_read();
        for (int i = 0; i < 20; i++) begin
            if1.ld_valid = 1'b1;
            if1.ld_addr  = 16'(i);
            if1.ld_data  = 32'h1000 + 32'(i);
            if (i == 0) begin
                #1;
                checks++; if (if1.ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready got=%b exp=1", if1.ld_ready); end
            end
            tick();
        end
        if1.ld_valid = 1'b0;
        // Reset the counters only; memory contents survive.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if1.mem_addr = 16'(i);
            tick();
            checks++; if (if1.mem_read_data !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL load_read[%0d] got=%h exp=%h", i, if1.mem_read_data, 32'h1000 + 32'(i)); end
        end
        checks++; if (cnt1 !== 16'd20) begin errors++; $display("FAIL rd_count got=%0d exp=20", cnt1); end
    endtask

    task automatic test_latency3();
        if3.mem_addr = 16'd9;
        if3.ld_valid = 1'b1;
        if3.ld_addr  = 16'd9;
        if3.ld_data  = 32'h9999_0009;
        tick();
        if3.ld_addr  = 16'd5;
        if3.ld_data  = 32'h5555_0005;
        tick();
        if3.ld_valid = 1'b0;
        repeat (3) tick();
        checks++; if (if3.mem_read_data !== 32'h9999_0009) begin errors++; $display("FAIL lat3_settle got=%h exp=99990009", if3.mem_read_data); end
        if3.mem_addr = 16'd5;
        tick();
        checks++; if (if3.mem_read_data !== 32'h9999_0009) begin errors++; $display("FAIL lat3_edge0 got=%h exp=99990009", if3.mem_read_data); end
        tick();
        checks++; if (if3.mem_read_data !== 32'h9999_0009) begin errors++; $display("FAIL lat3_edge1 got=%h exp=99990009", if3.mem_read_data); end
        tick();
        checks++; if (if3.mem_read_data !== 32'h5555_0005) begin errors++; $display("FAIL lat3_edge2 got=%h exp=55550005", if3.mem_read_data); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (if3.mem_read_data !== 32'h5555_0005) begin errors++; $display("FAIL lat3_hold[%0d] got=%h exp=55550005", i, if3.mem_read_data); end
        end
    endtask

    task automatic test_digest();
        for (int i = 7; i >= 0; i--) begin
            if1.mem_we         = 1'b1;
            if1.mem_addr       = 16'h0020 + 16'(i);
            if1.mem_write_data = 32'hAA00_0000 + 32'(i);
            tick();
            if (i > 0) begin
                checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL digest_early[%0d] got=%b exp=0", i, valid1); end
            end else begin
                checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL digest_full got=%b exp=1", valid1); end
            end
        end
        if1.mem_we = 1'b0;
        sel1 = 3'd3;
        #1;
        checks++; if (word1 !== 32'hAA00_0003) begin errors++; $display("FAIL digest_sel3 got=%h exp=aa000003", word1); end
        sel1 = 3'd7;
        #1;
        checks++; if (word1 !== 32'hAA00_0007) begin errors++; $display("FAIL digest_sel7 got=%h exp=aa000007", word1); end
        if1.mem_addr = 16'h0023;
        tick();
        checks++; if (if1.mem_read_data !== 32'hAA00_0003) begin errors++; $display("FAIL digest_memword got=%h exp=aa000003", if1.mem_read_data); end
    endtask

    task automatic test_ld_priority();
        if1.ld_valid = 1'b1;
        if1.ld_addr  = 16'h0041;
        if1.ld_data  = 32'h0000_1111;
        tick();
        if1.mem_we         = 1'b1;
        if1.mem_addr       = 16'h0040;
        if1.mem_write_data = 32'h0000_DEAD;
        if1.ld_data        = 32'h0000_BEEF;
        #1;
        checks++; if (if1.ld_ready !== 1'b0) begin errors++; $display("FAIL ldprio_blocked got=%b exp=0", if1.ld_ready); end
        tick();
        if1.mem_we   = 1'b0;
        if1.mem_addr = 16'h0041;
        #1;
        checks++; if (if1.ld_ready !== 1'b1) begin errors++; $display("FAIL ldprio_ready got=%b exp=1", if1.ld_ready); end
        tick();
        checks++; if (if1.mem_read_data !== 32'h0000_1111) begin errors++; $display("FAIL ldprio_readfirst got=%h exp=00001111", if1.mem_read_data); end
        if1.ld_valid = 1'b0;
        tick();
        checks++; if (if1.mem_read_data !== 32'h0000_BEEF) begin errors++; $display("FAIL ldprio_loaded got=%h exp=0000beef", if1.mem_read_data); end
        if1.mem_addr = 16'h0040;
        tick();
        checks++; if (if1.mem_read_data !== 32'h0000_DEAD) begin errors++; $display("FAIL ldprio_engwrite got=%h exp=0000dead", if1.mem_read_data); end
    endtask

    task automatic test_oor();
        checks++; if (oor1 !== 1'b0) begin errors++; $display("FAIL oor_before got=%b exp=0", oor1); end
        if1.mem_addr = 16'd260;
        tick();
        checks++; if (if1.mem_read_data !== 32'h0) begin errors++; $display("FAIL oor_rdata got=%h exp=0", if1.mem_read_data); end
        checks++; if (oor1 !== 1'b1) begin errors++; $display("FAIL oor_set got=%b exp=1", oor1); end
        if1.mem_addr = 16'h0041;
        tick();
        checks++; if (if1.mem_read_data !== 32'h0000_BEEF) begin errors++; $display("FAIL oor_validread got=%h exp=0000beef", if1.mem_read_data); end
        checks++; if (oor1 !== 1'b1) begin errors++; $display("FAIL oor_sticky_rd got=%b exp=1", oor1); end
        if1.mem_we         = 1'b1;
        if1.mem_addr       = 16'h0042;
        if1.mem_write_data = 32'h5;
        tick();
        if1.mem_we = 1'b0;
        checks++; if (oor1 !== 1'b1) begin errors++; $display("FAIL oor_sticky_wr got=%b exp=1", oor1); end
    endtask

    task automatic test_clr_and_reset();
        logic [2:0] others [6];
        others = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
        checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL clr_prevalid got=%b exp=1", valid1); end
        clr1               = 1'b1;
        if1.mem_we         = 1'b1;
        if1.mem_addr       = 16'h0022;
        if1.mem_write_data = 32'hBB00_0002;
        tick();
        clr1 = 1'b0;
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b exp=0", valid1); end
        sel1 = 3'd2;
        #1;
        checks++; if (word1 !== 32'hBB00_0002) begin errors++; $display("FAIL clr_word2 got=%h exp=bb000002", word1); end
        sel1 = 3'd3;
        #1;
        checks++; if (word1 !== 32'hAA00_0003) begin errors++; $display("FAIL clr_keepreg got=%h exp=aa000003", word1); end
        for (int j = 0; j < 6; j++) begin
            if1.mem_addr       = 16'h0020 + 16'(others[j]);
            if1.mem_write_data = 32'hCC00_0000 + 32'(others[j]);
            tick();
        end
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL clr_seven got=%b exp=0", valid1); end
        if1.mem_addr       = 16'h0027;
        if1.mem_write_data = 32'hCC00_0007;
        tick();
        checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL clr_refull got=%b exp=1", valid1); end

        // Read burst interrupted by an asynchronous reset between edges.
        if1.mem_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if1.mem_addr = 16'(i);
            tick();
        end
        checks++; if (if1.mem_read_data !== 32'h0000_1001) begin errors++; $display("FAIL burst_pre got=%h exp=00001001", if1.mem_read_data); end
        if1.ld_valid = 1'b1;
        if1.ld_addr  = 16'd3;
        if1.ld_data  = 32'h7777_7777;
        reset = 1'b1;
        #1;
        checks++; if (if1.mem_read_data !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", if1.mem_read_data); end
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL rst_dvalid got=%b exp=0", valid1); end
        checks++; if (oor1 !== 1'b0) begin errors++; $display("FAIL rst_oor got=%b exp=0", oor1); end
        checks++; if (cnt1 !== 16'h0) begin errors++; $display("FAIL rst_rdcount got=%0d exp=0", cnt1); end
        checks++; if (word1 !== 32'h0) begin errors++; $display("FAIL rst_dword got=%h exp=0", word1); end
        checks++; if (if1.ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ldready got=%b exp=0", if1.ld_ready); end
        // Neither an engine write nor a host load may land while reset is held.
        if1.mem_we         = 1'b1;
        if1.mem_addr       = 16'd2;
        if1.mem_write_data = 32'hFFFF_FFFF;
        tick();
        if1.mem_we   = 1'b0;
        if1.ld_valid = 1'b0;
        if1.mem_addr = 16'd2;
        reset = 1'b0;
        tick();
        checks++; if (if1.mem_read_data !== 32'h0000_1002) begin errors++; $display("FAIL rst_nowrite got=%h exp=00001002", if1.mem_read_data); end
        if1.mem_addr = 16'd3;
        tick();
        checks++; if (if1.mem_read_data !== 32'h0000_1003) begin errors++; $display("FAIL rst_noload got=%h exp=00001003", if1.mem_read_data); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        if1.mem_addr = 16'h0; if1.mem_we = 1'b0; if1.mem_write_data = 32'h0;
        if1.ld_valid = 1'b0;  if1.ld_addr = 16'h0; if1.ld_data = 32'h0;
        if3.mem_addr = 16'h0; if3.mem_we = 1'b0; if3.mem_write_data = 32'h0;
        if3.ld_valid = 1'b0;  if3.ld_addr = 16'h0; if3.ld_data = 32'h0;
        clr1 = 1'b0; sel1 = 3'd0;
        clr3 = 1'b0; sel3 = 3'd0;

        test_reset();
        test_load_read();
        test_latency3();
        test_digest();
        test_ld_priority();
        test_oor();
        test_clr_and_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
